// File: rtl/ctrl_sw_sequencer.sv
// Sync-locked arm/run/done sequencer driven by the ctrl_sw software word; outputs are 1 cycle after the input event.
// No backpressure: sync_in and ctrl_word are sampled every cycle and never stalled.
// Optional status readback (state, missed-sync count, acc_cnt) is built only when CTRL_SEQ_STATUS_EN is defined.
module ctrl_sw_sequencer #(
    parameter int CNT_W   = 16,
    parameter int RST_LEN = 4
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic [31:0]      ctrl_word,
    input  logic             sync_in,
    output logic             sync_out,
    output logic             acc_strobe,
    output logic             rst_out,
    output logic             armed,
    output logic             running,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [31:0]      status_word
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               arm_hist_q, arm_hist_d;
    logic               srst_hist_q, srst_hist_d;
    logic               sync_out_q, sync_out_d;
    logic               acc_strobe_q, acc_strobe_d;
    logic [3:0]         rst_cnt_q, rst_cnt_d;
    logic               rst_out_q, rst_out_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;

    logic               arm_edge;
    logic               srst_edge;
    logic               cont;
    logic [CNT_W-1:0]   n_acc;
    logic [CNT_W-1:0]   acc_inc;
    logic               unused_ctrl;

    assign arm_edge    = ctrl_word[0] & ~arm_hist_q;
    assign srst_edge   = ctrl_word[1] & ~srst_hist_q;
    assign cont        = ctrl_word[2];
    assign n_acc       = CNT_W'(ctrl_word[31:16]);
    assign acc_inc     = acc_cnt_q + CNT_W'(1);
    assign unused_ctrl = ^ctrl_word[15:3];

    always_comb begin
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q;
        sync_out_d   = 1'b0;
        acc_strobe_d = 1'b0;
        arm_hist_d   = ctrl_word[0];
        srst_hist_d  = ctrl_word[1];

        if (srst_edge) begin
            rst_cnt_d = 4'(RST_LEN);
        end else if (rst_cnt_q != 4'd0) begin
            rst_cnt_d = rst_cnt_q - 4'd1;
        end else begin
            rst_cnt_d = rst_cnt_q;
        end
        rst_out_d = (rst_cnt_d != 4'd0);

        // Soft reset outranks every other event in the same cycle, sync_in included.
        if (srst_edge) begin
            state_d   = ST_IDLE;
            acc_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arm_edge) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (sync_in) begin
                        state_d    = ST_RUN;
                        acc_cnt_d  = '0;
                        sync_out_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (sync_in) begin
                        sync_out_d   = 1'b1;
                        acc_strobe_d = 1'b1;
                        // N_ACC of zero disables the terminal compare; the counter free-wraps.
                        if ((n_acc != '0) && (acc_inc == n_acc)) begin
                            if (cont) begin
                                acc_cnt_d = '0;
                            end else begin
                                acc_cnt_d = acc_inc;
                                state_d   = ST_DONE;
                            end
                        end else begin
                            acc_cnt_d = acc_inc;
                        end
                    end
                end
                ST_DONE: begin
                    if (arm_edge) state_d = ST_ARMED;
                end
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        // Edge history keeps tracking the word through reset, so a bit held high across release never fires.
        arm_hist_q  <= arm_hist_d;
        srst_hist_q <= srst_hist_d;
        if (user_rst) begin
            state_q      <= ST_IDLE;
            acc_cnt_q    <= '0;
            sync_out_q   <= 1'b0;
            acc_strobe_q <= 1'b0;
            rst_cnt_q    <= 4'd0;
            rst_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            sync_out_q   <= sync_out_d;
            acc_strobe_q <= acc_strobe_d;
            rst_cnt_q    <= rst_cnt_d;
            rst_out_q    <= rst_out_d;
        end
    end

    assign sync_out   = sync_out_q;
    assign acc_strobe = acc_strobe_q;
    assign rst_out    = rst_out_q;
    assign acc_cnt    = acc_cnt_q;
    assign armed      = (state_q == ST_ARMED);
    assign running    = (state_q == ST_RUN);

`ifdef CTRL_SEQ_STATUS_EN
    logic       sync_hist_q, sync_hist_d;
    logic [7:0] missed_q, missed_d;

    always_comb begin
        sync_hist_d = sync_in;
        missed_d    = missed_q;
        // Back-to-back syncs in RUN mean the ADC sync gap collapsed to one cycle.
        if (srst_edge) begin
            missed_d = 8'd0;
        end else if (sync_in && sync_hist_q && (state_q == ST_RUN) && (missed_q != 8'hFF)) begin
            missed_d = missed_q + 8'd1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            sync_hist_q <= 1'b0;
            missed_q    <= 8'd0;
        end else begin
            sync_hist_q <= sync_hist_d;
            missed_q    <= missed_d;
        end
    end

    assign status_word = {state_q, 6'b0, missed_q, 16'(acc_cnt_q)};
`else
    assign status_word = 32'h0;
`endif

endmodule

// File: tb/tb_ctrl_sw_sequencer.sv
// Directed bench for ctrl_sw_sequencer: an event-level model checked every cycle plus literal expectations.
module tb_ctrl_sw_sequencer;
    localparam int RST_LEN = 4;

    logic        user_clk = 1'b0;
    logic        user_rst;
    logic [31:0] cw, cw4;
    logic        sync_in, sync4;

    logic        sync_out, acc_strobe, rst_out, armed, running;
    logic [15:0] acc_cnt;
    logic [31:0] status_word;
    logic        sync_out4, acc_strobe4, rst_out4, armed4, running4;
    logic [3:0]  acc_cnt4;
    logic [31:0] status_word4;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    always #5 user_clk = ~user_clk;

    ctrl_sw_sequencer #(.CNT_W(16), .RST_LEN(RST_LEN)) dut (
        .user_clk(user_clk), .user_rst(user_rst), .ctrl_word(cw), .sync_in(sync_in),
        .sync_out(sync_out), .acc_strobe(acc_strobe), .rst_out(rst_out), .armed(armed),
        .running(running), .acc_cnt(acc_cnt), .status_word(status_word)
    );

    ctrl_sw_sequencer #(.CNT_W(4), .RST_LEN(RST_LEN)) dut4 (
        .user_clk(user_clk), .user_rst(user_rst), .ctrl_word(cw4), .sync_in(sync4),
        .sync_out(sync_out4), .acc_strobe(acc_strobe4), .rst_out(rst_out4), .armed(armed4),
        .running(running4), .acc_cnt(acc_cnt4), .status_word(status_word4)
    );

    // mode: 0 idle, 1 armed, 2 run, 3 done
    typedef struct {
        int mode;
        int cnt;
        int rst_left;
        bit sync_o;
        bit strobe_o;
        bit arm_h;
        bit srst_h;
        bit sync_h;
        int missed;
    } mdl_t;

    mdl_t m16, m4;

    function automatic mdl_t step(input mdl_t m, input bit rst, input logic [31:0] w,
                                  input bit sync, input int cnt_w);
        mdl_t n;
        int   modulus, nacc, nxt;
        bit   arm_e, srst_e;
        n = m;
        n.sync_o   = 1'b0;
        n.strobe_o = 1'b0;
        n.arm_h    = w[0];
        n.srst_h   = w[1];
        if (rst) begin
            n.mode = 0; n.cnt = 0; n.rst_left = 0; n.sync_h = 1'b0; n.missed = 0;
            return n;
        end
        n.sync_h = sync;
        modulus  = 1 << cnt_w;
        nacc     = int'(w[31:16]) % modulus;
        arm_e    = w[0] && !m.arm_h;
        srst_e   = w[1] && !m.srst_h;
        n.rst_left = srst_e ? RST_LEN : ((m.rst_left > 0) ? m.rst_left - 1 : 0);
        if (srst_e) n.missed = 0;
        else if (sync && m.sync_h && m.mode == 2 && m.missed < 255) n.missed = m.missed + 1;
        if (srst_e) begin
            n.mode = 0;
            n.cnt  = 0;
        end else begin
            case (m.mode)
                0: if (arm_e) n.mode = 1;
                1: if (sync) begin n.mode = 2; n.cnt = 0; n.sync_o = 1'b1; end
                2: if (sync) begin
                    n.sync_o   = 1'b1;
                    n.strobe_o = 1'b1;
                    nxt = (m.cnt + 1) % modulus;
                    if (nacc != 0 && nxt == nacc) begin
                        if (w[2]) n.cnt = 0;
                        else begin n.cnt = nxt; n.mode = 3; end
                    end else begin
                        n.cnt = nxt;
                    end
                end
                default: if (arm_e) n.mode = 1;
            endcase
        end
        return n;
    endfunction

    function automatic logic [31:0] status_exp(input mdl_t m);
        logic [31:0] s;
        s = 32'h0;
`ifdef CTRL_SEQ_STATUS_EN
        s[31:30] = m.mode[1:0];
        s[23:16] = m.missed[7:0];
        s[15:0]  = m.cnt[15:0];
`endif
        return s;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge user_clk) begin
        m16 = step(m16, user_rst, cw, sync_in, 16);
        m4  = step(m4, user_rst, cw4, sync4, 4);
    end

    always @(negedge user_clk) begin
        if (cmp_en) begin
            cmp("sync_out", 32'(sync_out), 32'(m16.sync_o));
            cmp("acc_strobe", 32'(acc_strobe), 32'(m16.strobe_o));
            cmp("rst_out", 32'(rst_out), 32'(m16.rst_left != 0));
            cmp("armed", 32'(armed), 32'(m16.mode == 1));
            cmp("running", 32'(running), 32'(m16.mode == 2));
            cmp("acc_cnt", 32'(acc_cnt), m16.cnt);
            cmp("status_word", status_word, status_exp(m16));
            cmp("sync_out4", 32'(sync_out4), 32'(m4.sync_o));
            cmp("acc_strobe4", 32'(acc_strobe4), 32'(m4.strobe_o));
            cmp("running4", 32'(running4), 32'(m4.mode == 2));
            cmp("acc_cnt4", 32'(acc_cnt4), m4.cnt);
            cmp("status_word4", status_word4, status_exp(m4));
        end
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_sync();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
    endtask

    initial begin
        int highs;
        int exp3 [5] = '{1, 0, 1, 0, 1};

        user_rst = 1'b1; cw = 32'h1; cw4 = 32'h0; sync_in = 1'b0; sync4 = 1'b0;
        tick();
        cmp_en = 1'b1;
        ticks(2);
        cmp("rst_rst_out", 32'(rst_out), 0);
        cmp("rst_acc_cnt", 32'(acc_cnt), 0);
        cmp("rst_armed", 32'(armed), 0);

        // Reset release with ARM held high must not arm.
        user_rst = 1'b0;
        ticks(3);
        cmp("t1_held_no_arm", 32'(armed), 0);
        cw = 32'h0; tick();
        cw = 32'h1; tick();
        cmp("t1_arm_edge", 32'(armed), 1);

        // N_ACC=3, single shot.
        cw = 32'h0003_0001; tick();
        for (int i = 0; i < 4; i++) begin
            pulse_sync();
            cmp("t2_sync_out", 32'(sync_out), 1);
            if (i == 0) begin
                cmp("t2_run", 32'(running), 1);
                cmp("t2_first_no_strobe", 32'(acc_strobe), 0);
            end else begin
                cmp("t2_strobe", 32'(acc_strobe), 1);
                cmp("t2_acc_cnt", 32'(acc_cnt), i);
            end
            ticks(99);
        end
        cmp("t2_done_not_running", 32'(running), 0);
        pulse_sync();
        cmp("t2_done_no_sync", 32'(sync_out), 0);
        ticks(5);

        // N_ACC=2, continuous.
        cw = 32'h0002_0004; tick();
        cw = 32'h0002_0005; tick();
        cmp("t3_rearm", 32'(armed), 1);
        pulse_sync(); ticks(9);
        for (int i = 0; i < 5; i++) begin
            pulse_sync();
            cmp("t3_acc_cnt", 32'(acc_cnt), exp3[i]);
            cmp("t3_running", 32'(running), 1);
            ticks(9);
        end

        // SRST + ARM + sync together while running.
        cw = 32'h0002_0004; tick();
        cw = 32'h0002_0007; sync_in = 1'b1; tick(); sync_in = 1'b0;
        cmp("t4_no_sync_out", 32'(sync_out), 0);
        cmp("t4_not_armed", 32'(armed), 0);
        cmp("t4_not_running", 32'(running), 0);
        cmp("t4_acc_cnt", 32'(acc_cnt), 0);
        highs = rst_out ? 1 : 0;
        for (int i = 0; i < 20; i++) begin tick(); if (rst_out) highs++; end
        cmp("t4_rst_len", highs, 4);

        // SRST re-edge while rst_out high restarts the count.
        cw = 32'h0002_0005; tick();
        cw = 32'h0002_0007; tick(); highs = rst_out ? 1 : 0;
        cw = 32'h0002_0005; tick(); if (rst_out) highs++;
        cw = 32'h0002_0007; tick(); if (rst_out) highs++;
        for (int i = 0; i < 20; i++) begin tick(); if (rst_out) highs++; end
        cmp("t4_rst_restart_len", highs, 6);

        // ARM edge during rst_out pulse, then user_rst drops the pulse.
        cw = 32'h0002_0004; tick();
        cw = 32'h0002_0006; tick();
        cw = 32'h0002_0005; tick();
        cmp("t4_arm_during_rst", 32'(armed), 1);
        cmp("t4_rst_still_high", 32'(rst_out), 1);
        user_rst = 1'b1; tick();
        cmp("t4_user_rst_drop", 32'(rst_out), 0);
        user_rst = 1'b0; ticks(3);
        cmp("t4_user_rst_idle", 32'(armed), 0);

        // Consecutive syncs in RUN.
        cw = 32'h0000_0004; tick();
        cw = 32'h0000_0005; tick();
        pulse_sync(); ticks(4);
        sync_in = 1'b1; ticks(3); sync_in = 1'b0; tick();
        cmp("t5_acc_cnt", 32'(acc_cnt), 3);
`ifdef CTRL_SEQ_STATUS_EN
        cmp("t5_missed", 32'(status_word[23:16]), 2);
        cmp("t5_state", 32'(status_word[31:30]), 2);
        cw = 32'h0000_0006; tick();
        cmp("t5_missed_clr", 32'(status_word[23:16]), 0);
`else
        cmp("t5_status_zero", status_word, 0);
        cw = 32'h0000_0006; tick();
        cmp("t5_status_zero_idle", status_word, 0);
`endif

        // CNT_W=4, N_ACC=0 free-wraps.
        cw4 = 32'h0000_0001; tick();
        sync4 = 1'b1; tick(); sync4 = 1'b0; ticks(2);
        for (int k = 1; k <= 17; k++) begin
            sync4 = 1'b1; tick(); sync4 = 1'b0;
            if (k == 15) cmp("t6_cnt15", 32'(acc_cnt4), 15);
            if (k == 16) cmp("t6_wrap0", 32'(acc_cnt4), 0);
            if (k == 17) cmp("t6_cnt1", 32'(acc_cnt4), 1);
            cmp("t6_running", 32'(running4), 1);
            tick();
        end

        ticks(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
